// File: rtl/downstream_write_engine.sv
// downstream_write_engine: round-robin arbitration of NUM_CH write requesters into a
// FIFO, with each queued write issued downstream over a req/ack handshake. Completion
// pulses are returned per channel. A stalled write is aborted by a timeout, which also
// sets a sticky error flag.
module downstream_write_engine #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               memwr,
  input  logic [NUM_CH*ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]        wr_data,
  output logic [NUM_CH-1:0]               grant,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_data,
  output logic [$clog2(NUM_CH)-1:0]       mem_ch,
  input  logic                            ack,
  output logic [NUM_CH-1:0]               out,
  output logic                            err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int          CH_W    = $clog2(NUM_CH);
  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam int          TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned NCH     = NUM_CH;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TO_W-1:0]     wait_q, wait_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [CH_W-1:0]     mem_ch_q, mem_ch_d;
  logic [NUM_CH-1:0]   out_q, out_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
  logic [CH_W-1:0]     ch_mem   [FIFO_DEPTH];

  logic                full, empty, push, pop, timeout_hit, found;
  logic [CH_W-1:0]     grant_idx;
  int unsigned         idx;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign timeout_hit = (TIMEOUT != 0) && (32'(wait_q) == TO_LAST);

  // Round-robin arbiter: search starts one past the last granted channel.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (!full && (memwr != '0)) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        idx = (32'(last_q) + 1 + i) % NCH;
        if (!found && memwr[CH_W'(idx)]) begin
          found            = 1'b1;
          grant[CH_W'(idx)] = 1'b1;
          grant_idx        = CH_W'(idx);
        end
      end
    end
  end

  assign push = found;

  // Next-state for the issue FSM, FIFO pointers and registered outputs.
  always_comb begin
    state_d    = state_q;
    last_d     = push ? grant_idx : last_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_ch_d   = mem_ch_q;
    wait_d     = wait_q;
    out_d      = '0;
    err_d      = err_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack || timeout_hit) begin
          // ack wins over a timeout landing on the same cycle
          if (ack) out_d[mem_ch_q] = 1'b1;
          else     err_d           = 1'b1;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      mem_req_d  = 1'b1;
      mem_addr_d = addr_mem[rd_ptr_q];
      mem_data_d = data_mem[rd_ptr_q];
      mem_ch_d   = ch_mem[rd_ptr_q];
      wait_d     = '0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr[grant_idx*ADDR_W +: ADDR_W];
      data_mem[wr_ptr_q] <= wr_data[grant_idx*DATA_W +: DATA_W];
      ch_mem[wr_ptr_q]   <= grant_idx;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= CH_W'(NUM_CH - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_ch_q   <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_ch_q   <= mem_ch_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_ch     = mem_ch_q;
  assign out        = out_q;
  assign err        = err_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_downstream_write_engine.sv
// Directed bench for downstream_write_engine with default parameters.
module tb_downstream_write_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   memwr = '0;
  logic [63:0]  wr_addr;
  logic [127:0] wr_data;
  logic [3:0]   grant;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_data;
  logic [1:0]   mem_ch;
  logic         ack = 1'b0;
  logic [3:0]   out;
  logic         err;
  logic [2:0]   fifo_count;

  int checks = 0;
  int errors = 0;

  downstream_write_engine #(
    .NUM_CH(4), .DATA_W(32), .ADDR_W(16), .FIFO_DEPTH(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .memwr(memwr), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant(grant), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ch(mem_ch), .ack(ack), .out(out), .err(err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] memwr;
    logic       ack;
    logic [3:0] grant;
    logic       mem_req;
    logic [1:0] mem_ch;
    logic [3:0] out;
    logic [2:0] count;
    logic       err;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [15:0] addr_of(input int ch);
    return 16'h1100 + 16'(ch);
  endfunction

  function automatic logic [31:0] data_of(input int ch);
    return 32'hCAFE_0000 + 32'(ch);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_default_payload();
    for (int i = 0; i < 4; i++) begin
      wr_addr[i*16 +: 16] = addr_of(i);
      wr_data[i*32 +: 32] = data_of(i);
    end
  endtask

  // Reset held over two edges, released at a falling edge.
  task automatic do_reset();
    rst   = 1'b1;
    memwr = '0;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0, n1, outs, first1;
    logic err_at16;

    set_default_payload();
    // rows: memwr, ack | grant, mem_req, mem_ch, out, fifo_count, err
    tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0, 4'h0, 3'd1, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b1, 2'd0, 4'h0, 3'd1, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b1, 2'd0, 4'h0, 3'd2, 1'b0};
    tbl[4]  = '{4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0, 3'd3, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 3'd4, 1'b0};
    tbl[6]  = '{4'h1, 1'b1, 4'h0, 1'b1, 2'd0, 4'h0, 3'd4, 1'b0};
    tbl[7]  = '{4'h1, 1'b0, 4'h1, 1'b1, 2'd1, 4'h1, 3'd3, 1'b0};
    tbl[8]  = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 4'h0, 3'd4, 1'b0};
    tbl[9]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 4'h0, 3'd4, 1'b0};
    tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 4'h2, 3'd3, 1'b0};
    tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 4'h4, 3'd2, 1'b0};
    tbl[12] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 4'h8, 3'd1, 1'b0};
    tbl[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 4'h1, 3'd0, 1'b0};
    tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 3'd0, 1'b0};
    tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    do_reset();

    // Table: RR fill to full, full+pop same cycle, then back-to-back drain
    for (int r = 0; r < 16; r++) begin
      memwr = tbl[r].memwr;
      ack   = tbl[r].ack;
      #1;
      chk($sformatf("row%0d_grant", r), 64'(grant), 64'(tbl[r].grant));
      chk($sformatf("row%0d_mem_req", r), 64'(mem_req), 64'(tbl[r].mem_req));
      chk($sformatf("row%0d_out", r), 64'(out), 64'(tbl[r].out));
      chk($sformatf("row%0d_count", r), 64'(fifo_count), 64'(tbl[r].count));
      chk($sformatf("row%0d_err", r), 64'(err), 64'(tbl[r].err));
      if (tbl[r].mem_req) begin
        chk($sformatf("row%0d_mem_ch", r), 64'(mem_ch), 64'(tbl[r].mem_ch));
        chk($sformatf("row%0d_mem_addr", r), 64'(mem_addr), 64'(addr_of(int'(tbl[r].mem_ch))));
        chk($sformatf("row%0d_mem_data", r), 64'(mem_data), 64'(data_of(int'(tbl[r].mem_ch))));
      end
      @(negedge clk);
    end

    // Async reset mid-transfer with three entries queued
    memwr = 4'hF;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    #2;
    memwr = '0;
    rst   = 1'b1;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_ch", 64'(mem_ch), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    memwr = 4'hF;
    #1;
    chk("postrst_grant", 64'(grant), 64'h1);
    @(negedge clk);
    do_reset();

    // Single write: latency and payload
    wr_addr[2*16 +: 16] = 16'h0040;
    wr_data[2*32 +: 32] = 32'hDEADBEEF;
    memwr = 4'b0100;
    #1;
    chk("lat_grant_c0", 64'(grant), 64'h4);
    @(negedge clk);
    memwr = '0;
    #1;
    chk("lat_req_c1", 64'(mem_req), 64'd0);
    @(negedge clk);
    #1;
    chk("lat_req_c2", 64'(mem_req), 64'd1);
    chk("lat_ch_c2", 64'(mem_ch), 64'd2);
    chk("lat_addr_c2", 64'(mem_addr), 64'h0040);
    chk("lat_data_c2", 64'(mem_data), 64'hDEADBEEF);
    repeat (3) @(negedge clk);
    ack = 1'b1;
    #1;
    chk("lat_out_c5", 64'(out), 64'h0);
    chk("lat_req_c5", 64'(mem_req), 64'd1);
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("lat_out_c6", 64'(out), 64'h4);
    chk("lat_req_c6", 64'(mem_req), 64'd0);
    @(negedge clk);
    #1;
    chk("lat_out_c7", 64'(out), 64'h0);
    set_default_payload();
    do_reset();

    // Timeout: two entries, no ack ever
    n0 = 0; n1 = 0; outs = 0; first1 = -1; err_at16 = 1'bx;
    for (int c = 0; c < 45; c++) begin
      memwr = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      #1;
      if (mem_req && mem_ch == 2'd0) n0++;
      if (mem_req && mem_ch == 2'd1) begin
        n1++;
        if (first1 < 0) first1 = c;
      end
      if (out != '0) outs++;
      if (c == 16) err_at16 = err;
      @(negedge clk);
    end
    #1;
    chk("to_ch0_cycles", 64'(n0), 64'd15);
    chk("to_ch1_cycles", 64'(n1), 64'd15);
    chk("to_ch1_start", 64'(first1), 64'd17);
    chk("to_err_before", 64'(err_at16), 64'd0);
    chk("to_err_sticky", 64'(err), 64'd1);
    chk("to_no_out", 64'(outs), 64'd0);
    chk("to_req_end", 64'(mem_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
